// File: rtl/imem_fetch_unit.sv
// Instruction fetch stage in front of a synchronous-read ROM: owns the PC, byte-swaps
// the ROM word to little-endian and hands {pc, inst} to decode.
module imem_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [29:0]      imem_addr,
    input  logic [31:0]      imem_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             halt_req,
    output logic             halted,
    output logic             misaligned_seen,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic [31:0] req_pc;
    logic        req_valid;
    logic [31:0] hold_pc;

    logic        live;
    logic        fire;
    logic        stall;
    logic [31:0] redirect_tgt;
    logic [31:0] next_pc;
    logic [31:0] halt_pc;

    // Handshake: a transfer happens on a rising edge where out_valid && out_ready.
    // Once out_valid is high, out_pc/out_inst hold until that transfer, unless a
    // redirect kills the word (out_valid drops in that same cycle).
    assign live         = req_valid && !redirect_valid;
    assign out_valid    = live && (state == RUN);
    assign fire         = out_valid && out_ready;
    assign stall        = out_valid && !out_ready;
    assign out_pc       = req_pc;
    assign out_inst     = {imem_inst[7:0], imem_inst[15:8], imem_inst[23:16], imem_inst[31:24]};
    assign halted       = (state == HALT);
    assign state_dbg    = state;
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign halt_pc      = redirect_valid ? redirect_tgt : hold_pc;

    // Re-presenting req_pc while stalled keeps the ROM output stable without a skid buffer.
    always_comb begin
        next_pc = req_pc;
        if (redirect_valid) begin
            next_pc = redirect_tgt;
        end else if (fire) begin
            next_pc = req_pc + 32'd4;
        end
    end

    always_comb begin
        imem_addr = RESET_PC[31:2];
        case (state)
            RUN:     imem_addr = next_pc[31:2];
            HALT:    imem_addr = halt_pc[31:2];
            default: imem_addr = RESET_PC[31:2];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BOOT;
            req_pc    <= RESET_PC;
            req_valid <= 1'b0;
            hold_pc   <= RESET_PC;
        end else begin
            case (state)
                BOOT: begin
                    state     <= RUN;
                    req_pc    <= RESET_PC;
                    req_valid <= 1'b1;
                end
                RUN: begin
                    req_pc    <= next_pc;
                    req_valid <= 1'b1;
                    // Only halt once nothing valid is waiting on decode.
                    if (halt_req && (!live || fire)) begin
                        state     <= HALT;
                        hold_pc   <= next_pc;
                        req_valid <= 1'b0;
                    end
                end
                HALT: begin
                    hold_pc <= halt_pc;
                    req_pc  <= halt_pc;
                    if (!halt_req) begin
                        state     <= RUN;
                        req_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= BOOT;
                    req_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt       <= '0;
            stall_cnt       <= '0;
            misaligned_seen <= 1'b0;
        end else begin
            if (fire) begin
                fetch_cnt <= fetch_cnt + CNT_ONE;
            end
            if (stall) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                misaligned_seen <= 1'b1;
            end
        end
    end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the synchronous-read instruction ROM.
- The ROM registers a 30-bit word address every clock and returns the 32-bit word one cycle later.
- This block owns the PC, drives the ROM address, and converts the ROM's byte-reversed word to RISC-V little-endian order.
- It presents {pc, inst} to decode with a valid/ready handshake and handles stall, redirect (branch/jump), and debug halt.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetched instruction; bits [1:0] must be 0.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; asserting (low) clears state immediately; release is synchronous to clk.
- imem_addr  out  30  word address to ROM; combinational from state and inputs; ROM samples it every edge.
- imem_inst  in  32  ROM data, byte-reversed; corresponds to the address sampled at the previous edge.
- out_valid  out  1  decode-side valid.
- out_ready  in  1  decode-side ready; transfer occurs when out_valid && out_ready.
- out_pc  out  32  byte PC of out_inst.
- out_inst  out  32  instruction, little-endian: {imem_inst[7:0], imem_inst[15:8], imem_inst[23:16], imem_inst[31:24]}.
- redirect_valid  in  1  branch/jump taken; kills the in-flight instruction.
- redirect_pc  in  32  target byte address; bits [1:0] are ignored (forced 0), and misaligned_seen is set if they are nonzero.
- halt_req  in  1  debug halt request (level).
- halted  out  1  state == HALT.
- misaligned_seen  out  1  sticky flag; cleared only by reset.
- fetch_cnt  out  CNT_W  count of accepted transfers; wraps.
- stall_cnt  out  CNT_W  count of cycles with out_valid && !out_ready; wraps.

Behaviour:
- State registers: state {BOOT, RUN, HALT}, req_pc[31:0] (PC whose word the ROM returns this cycle), req_valid, hold_pc[31:0], the two counters, and misaligned_seen.
- Reset (rst low): state = BOOT, req_pc = RESET_PC, req_valid = 0, hold_pc = RESET_PC, counters = 0, misaligned_seen = 0.
  - Outputs during reset: out_valid = 0, halted = 0, imem_addr = RESET_PC[31:2].
- Derived signals:
  - live = req_valid && !redirect_valid
  - out_valid = live && (state == RUN)
  - out_pc = req_pc
  - fire = out_valid && out_ready
- next_pc priority:
  1. redirect_valid -> {redirect_pc[31:2], 2'b00}
  2. fire -> req_pc + 4 (32-bit wrap)
  3. else -> req_pc (re-present the same address, so the ROM output holds stable while stalled; no extra buffer)
- BOOT:
  - imem_addr = RESET_PC[31:2]; next state RUN.
  - req_pc <= RESET_PC, req_valid <= 1.
  - First instruction is valid in the 2nd cycle after reset release.
- RUN:
  - imem_addr = next_pc[31:2]; req_pc <= next_pc; req_valid <= 1.
  - Redirect latency: redirect asserted in cycle N -> out_valid = 0 in N (in-flight word killed, never transferred) -> target word valid in N+1.
  - Entering HALT: if halt_req && (!live || fire), go HALT with hold_pc <= next_pc and req_valid <= 0.
  - A pending, unaccepted instruction is never dropped by halt.
- HALT:
  - imem_addr = hold_pc[31:2]; req_pc <= hold_pc; out_valid = 0; halted = 1.
  - redirect_valid in HALT: hold_pc <= {redirect_pc[31:2], 2'b00}; imem_addr follows the new target in the same cycle.
  - halt_req low: next state RUN, req_valid <= 1. The word at hold_pc is then valid on the first RUN cycle; zero refetch penalty.
- Simultaneous events:
  - redirect with fire: redirect wins (the transfer is suppressed because out_valid = 0).
  - redirect with halt_req in RUN: enter HALT with hold_pc = target.
- Counters:
  - fetch_cnt += 1 on fire.
  - stall_cnt += 1 on out_valid && !out_ready.
  - Both wrap from all-ones to 0.
- misaligned_seen <= 1 on redirect_valid && |redirect_pc[1:0], in any state.
- Reset asserted mid-operation: all state clears immediately (asynchronous); any in-flight instruction is discarded, and fetch restarts from RESET_PC through BOOT.

Test Plan:
- Release reset, out_ready = 1, ROM word[0] = 32'h93031000, word[1] = 32'hb7000010 -> cycle 2: out_valid = 1, out_pc = 0, out_inst = 32'h00100393; cycle 3: out_pc = 4, out_inst = 32'h100000b7; fetch_cnt = 2 after cycle 3.
- Hold out_ready = 0 for 3 cycles at pc 8 -> imem_addr stays 2, out_inst stable, stall_cnt = 3; raise ready -> next pc 12.
- redirect_valid with redirect_pc = 32'h1C0 while the pc-0x10 word is valid -> no transfer that cycle; imem_addr = 0x70; next cycle out_pc = 0x1C0, out_inst = byteswap(word[0x70]).
- redirect_pc = 32'h1C2 -> fetch proceeds at 0x1C0; misaligned_seen = 1 and stays 1 until reset.
- halt_req = 1 while pc-0x20 is stalled -> stays RUN until the transfer; then halted = 1, out_valid = 0; redirect to 0x40 during HALT; drop halt_req -> next cycle out_pc = 0x40.
- Assert rst low mid-stream at pc 0x30 -> out_valid = 0 immediately, counters = 0; after release, BOOT then out_pc = RESET_PC.
